// File: rtl/decode_toggle_monitor_pkg.sv
// Shared constants and state type for the decode toggle monitor.
// Holds default vector width, window length and the derived widths.
// No logic; imported by the monitor and its bench.
package decode_toggle_monitor_pkg;

    localparam int VEC_W   = 47;
    localparam int WIN_LEN = 256;
    // Accumulator sized to hold VEC_W*WIN_LEN exactly, so it can never wrap.
    localparam int ACC_W   = $clog2(VEC_W * WIN_LEN + 1);
    localparam int PK_W    = $clog2(VEC_W + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/decode_toggle_monitor_if.sv
// Handshake bundle between decoder, toggle monitor and result consumer.
// Carries the sample stream (in_*) and the per-window result (out_*).
// slave = monitor side, master = surrounding environment side.
interface decode_toggle_monitor_if #(
    parameter int VEC_W = 47,
    parameter int ACC_W = 14,
    parameter int PK_W  = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_toggles;
    logic [PK_W-1:0]  out_peak;

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_toggles,
        output out_peak
    );

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_toggles,
        input  out_peak
    );
endinterface

// File: rtl/decode_toggle_monitor_popcount_vec.sv
// Counts bits that differ between two vectors (popcount of a XOR b).
// Latency: purely combinational.
// Backpressure: none, no handshake.
// Ports: a, b (W bits) in; cnt ($clog2(W+1) bits) out.
module popcount_vec #(
    parameter int W  = 47,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [CW-1:0] cnt
);
    logic [W-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(diff[i]);
        end
    end
endmodule

// File: rtl/decode_toggle_monitor.sv
// Measures bit toggles of a decoded vector stream over fixed-length windows.
// Latency: result registered, out_valid one cycle after the last window sample.
// Backpressure: in_ready low while a result waits for out_ready; nothing lost.
// Ports: clk, rst_n (async active-low); bus (slave) carries in_* and out_*.
module decode_toggle_monitor #(
    parameter int VEC_W   = decode_toggle_monitor_pkg::VEC_W,
    parameter int WIN_LEN = decode_toggle_monitor_pkg::WIN_LEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    decode_toggle_monitor_if.slave  bus
);
    import decode_toggle_monitor_pkg::*;

    localparam int ACC_W = $clog2(VEC_W * WIN_LEN + 1);
    localparam int PK_W  = $clog2(VEC_W + 1);
    localparam int CNT_W = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

    state_t           state;
    logic [VEC_W-1:0] prev;
    logic             first_seen;
    logic [ACC_W-1:0] acc;
    logic [PK_W-1:0]  peak;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] out_toggles_q;
    logic [PK_W-1:0]  out_peak_q;
    logic             out_valid_q;

    logic [PK_W-1:0]  raw_tog;
    logic [PK_W-1:0]  tog;
    logic             accept;
    logic [ACC_W-1:0] acc_nxt;
    logic [PK_W-1:0]  peak_nxt;

    popcount_vec #(.W(VEC_W), .CW(PK_W)) u_popcount (
        .a   (bus.in_vec),
        .b   (prev),
        .cnt (raw_tog)
    );

    assign bus.in_ready    = (state == ACCUM);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_toggles = out_toggles_q;
    assign bus.out_peak    = out_peak_q;

    assign accept   = bus.in_valid && (state == ACCUM);
    // The very first sample after reset has nothing to compare against.
    assign tog      = first_seen ? raw_tog : '0;
    assign acc_nxt  = acc + ACC_W'(tog);
    assign peak_nxt = (tog > peak) ? tog : peak;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACCUM;
            prev          <= '0;
            first_seen    <= 1'b0;
            acc           <= '0;
            peak          <= '0;
            cnt           <= '0;
            out_toggles_q <= '0;
            out_peak_q    <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        // prev survives window boundaries on purpose.
                        prev       <= bus.in_vec;
                        first_seen <= 1'b1;
                        acc        <= acc_nxt;
                        peak       <= peak_nxt;
                        if (cnt == LAST_IDX) begin
                            out_toggles_q <= acc_nxt;
                            out_peak_q    <= peak_nxt;
                            out_valid_q   <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        acc         <= '0;
                        peak        <= '0;
                        cnt         <= '0;
                        out_valid_q <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_toggle_monitor.sv
// Directed bench for decode_toggle_monitor with a window-level reference model.
// The model keeps each window's toggle counts in a queue and sums them at the end.
// A negedge compare process checks handshake and result outputs every cycle.
module tb_decode_toggle_monitor;
    import decode_toggle_monitor_pkg::*;

    logic clk;
    logic rst_n;

    decode_toggle_monitor_if #(.VEC_W(VEC_W), .ACC_W(ACC_W), .PK_W(PK_W)) bus ();

    decode_toggle_monitor #(.VEC_W(VEC_W), .WIN_LEN(WIN_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model state.
    logic [VEC_W-1:0] m_prev;
    bit               m_first;
    int               tq[$];
    bit               m_hold;
    longint           m_t;
    longint           m_p;
    longint           got_t[$];
    longint           got_p[$];

    function automatic void chk(string name, longint got, longint exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    initial begin
        m_prev = '0; m_first = 0; m_hold = 0; m_t = 0; m_p = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_prev = '0; m_first = 0; m_hold = 0; m_t = 0; m_p = 0;
                tq.delete();
            end else if (m_hold) begin
                if (bus.out_ready) begin
                    got_t.push_back(longint'(bus.out_toggles));
                    got_p.push_back(longint'(bus.out_peak));
                    m_hold = 0;
                end
            end else if (bus.in_valid) begin
                int t;
                t = m_first ? $countones(bus.in_vec ^ m_prev) : 0;
                m_prev  = bus.in_vec;
                m_first = 1;
                tq.push_back(t);
                if (tq.size() == WIN_LEN) begin
                    m_t = 0; m_p = 0;
                    foreach (tq[k]) begin
                        m_t += tq[k];
                        if (tq[k] > m_p) m_p = tq[k];
                    end
                    tq.delete();
                    m_hold = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", longint'(bus.in_ready), longint'(!m_hold));
        chk("out_valid", longint'(bus.out_valid), longint'(m_hold));
        if (m_hold) begin
            chk("out_toggles", longint'(bus.out_toggles), m_t);
            chk("out_peak", longint'(bus.out_peak), m_p);
        end
    end

    task automatic send(input logic [VEC_W-1:0] v);
        int  waited;
        bit  r;
        bit  done;
        waited = 0;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        while (!done) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            if (r) done = 1;
            else begin
                waited++;
                if (waited > 100) begin
                    nvec++; nerr++;
                    $display("FAIL send_timeout: in_ready stuck at 0, required 1");
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    logic [VEC_W-1:0] all1;
    logic [VEC_W-1:0] all0;
    logic [VEC_W-1:0] cvec;
    longint           held_t;
    longint           held_p;

    initial begin
        all1 = '1;
        all0 = '0;
        cvec = VEC_W'(47'h1234);
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b1;

        // Reset state, checked with literals while reset is still asserted.
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_toggles", longint'(bus.out_toggles), 0);
        chk("rst_out_peak", longint'(bus.out_peak), 0);
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        rst_n = 1'b1;
        idle(2);

        // Constant vector: no toggles at all.
        for (int i = 0; i < WIN_LEN; i++) send(cvec);
        bus.in_valid = 1'b0;
        chk("const_valid_next_cycle", longint'(bus.out_valid), 1);
        idle(3);

        // Alternating 0/1 from a fresh reset, consumer stalled.
        do_reset(2);
        idle(1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < WIN_LEN; i++) send((i % 2 == 0) ? all0 : all1);
        bus.in_vec = all0;
        held_t = longint'(bus.out_toggles);
        held_p = longint'(bus.out_peak);
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", longint'(bus.in_ready), 0);
            chk("bp_toggles_stable", longint'(bus.out_toggles), held_t);
            chk("bp_peak_stable", longint'(bus.out_peak), held_p);
            @(posedge clk);
            #1;
        end
        chk("bp_held_toggles", held_t, 11985);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after_pulse", longint'(bus.in_ready), 1);

        // Window 2 starts on all-0 after window 1 ended on all-1.
        for (int i = 0; i < WIN_LEN; i++) send(all0);
        idle(3);

        // Abort a window with reset at sample 100.
        for (int i = 0; i < 100; i++) send((i % 2 == 0) ? all0 : all1);
        do_reset(2);
        idle(1);
        for (int i = 0; i < WIN_LEN; i++) send((i % 2 == 0) ? all0 : all1);
        idle(4);

        // Literal expectations for the four completed windows.
        chk("result_count", longint'(got_t.size()), 4);
        if (got_t.size() >= 4) begin
            chk("w_const_toggles", got_t[0], 0);
            chk("w_const_peak", got_p[0], 0);
            chk("w_alt_toggles", got_t[1], 11985);
            chk("w_alt_peak", got_p[1], 47);
            chk("w_cross_toggles", got_t[2], 47);
            chk("w_cross_peak", got_p[2], 47);
            chk("w_after_abort_toggles", got_t[3], 11985);
            chk("w_after_abort_peak", got_p[3], 47);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
